count_checker: RTL and testbench
================================

COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 Parameter WIDTH, default 4, sample width of the checked count stream.
REQ-002 Parameter LOCK_N, default 4, number of consecutive consistent samples required to lock (range 2..15).
REQ-003 Parameter ERR_W, default 8, width of the error counter.
REQ-004 The clock SHALL be clk (input, 1 bit); the reset SHALL be rstn (input, 1 bit), asynchronous, active-low.
REQ-005 valid  input  1  count sample qualifier; sample taken on rising clk when high.
REQ-006 count  input  WIDTH  observed counter value, expected to increment by 1 mod 2^WIDTH per valid sample.
REQ-007 clear  input  1  synchronous clear of err_cnt.
REQ-008 locked  output  1  high while state is LOCKED.
REQ-009 err_pulse  output  1  one-cycle pulse on a mismatch detected while LOCKED.
REQ-010 err_cnt  output  ERR_W  saturating count of err_pulse events.
REQ-011 wrap_pulse  output  1  one-cycle pulse when LOCKED and the sample is a correct wrap from all-ones to 0.
REQ-012 rst_seen  output  1  one-cycle pulse on a detected counter restart (see REQ-027).
REQ-013 expected  output  WIDTH  next expected value, i.e. last valid sample + 1 mod 2^WIDTH.

Function
REQ-014 All outputs SHALL be registered; a sample at edge N SHALL be reflected on outputs after edge N (latency 1 cycle).
REQ-015 FSM states: SEARCH, LOCKED; an internal run counter tracks consecutive consistent samples.
REQ-016 On every valid sample, expected SHALL update to count + 1, truncated to WIDTH bits.
REQ-017 SEARCH: if count == expected and run > 0, then run increments; otherwise run is set to 1.
REQ-018 SEARCH: when run reaches LOCK_N, the FSM SHALL enter LOCKED on the same edge.
REQ-019 LOCKED, count == expected: the FSM stays LOCKED with no error.
REQ-020 LOCKED, count != expected: err_pulse = 1; err_cnt increments; FSM goes to SEARCH; run = 1.
REQ-021 When valid is low, state, run, expected and err_cnt SHALL hold, and all pulses SHALL be 0.
REQ-022 err_cnt SHALL saturate at 2^ERR_W - 1 and never wrap.
REQ-023 When clear and an error occur on the same edge, err_cnt = 0 and err_pulse still asserts.
REQ-024 Pulses SHALL never assert in SEARCH, except rst_seen per REQ-027.

Reset
REQ-025 rstn low SHALL asynchronously force state SEARCH, run = 0, expected = 0, err_cnt = 0, and locked, err_pulse, wrap_pulse, rst_seen = 0.
REQ-026 Reset asserted mid-run SHALL discard lock; after release, a full LOCK_N consistent samples are needed to relock.

Configuration
REQ-027 With COUNT_CHECKER_RESTART_DETECT_EN defined: in LOCKED, a mismatching sample equal to 0 SHALL pulse rst_seen, SHALL NOT pulse err_pulse or increment err_cnt, and SHALL move the FSM to SEARCH with run = 1.
REQ-028 Without COUNT_CHECKER_RESTART_DETECT_EN: rst_seen SHALL be tied 0 (port retained), and a mismatching sample of 0 is an ordinary error.

Structure
REQ-029 Package count_checker_pkg SHALL hold the state enum typedef and default parameter constants (WIDTH, LOCK_N, ERR_W).
REQ-030 The saturating error counter with synchronous clear SHALL be a sub-module named sat_counter; all other logic SHALL be in count_checker.

Verification
REQ-031 Lock: after reset, feed valid samples 0,1,2,3 -> locked = 1 after the 4th edge; err_cnt = 0; expected = 4.
REQ-032 Wrap: while locked, feed 14,15,0 -> one wrap_pulse after the edge sampling 0; locked stays 1.
REQ-033 Error: while locked at expected = 7, feed 9 -> err_pulse one cycle, err_cnt = 1, locked = 0, expected = 10; then 10,11,12 -> relock.
REQ-034 Restart: while locked at expected = 9, feed 0 -> with macro, rst_seen = 1 and err_cnt unchanged; without macro, err_pulse = 1 and err_cnt + 1.
REQ-035 Saturation/clear: ERR_W = 2, force 5 errors -> err_cnt = 3; assert clear on the same edge as an error -> err_cnt = 0 and err_pulse = 1.
REQ-036 Gaps/reset: valid low for 3 cycles while locked -> outputs hold; rstn pulsed low mid-stream -> all outputs 0 immediately and locked = 0 until 4 new consistent samples.

Source files
------------

// File: rtl/count_checker_pkg.sv
// Shared types and default parameters for the count_checker block.
package count_checker_pkg;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_LOCK_N = 4;
    localparam int DEF_ERR_W  = 8;

    // The run counter only has to reach LOCK_N, which is at most 15.
    localparam int RUN_W = 4;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Next count: clear first, otherwise increment unless already at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register, asynchronously cleared.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/count_checker.sv
// Checks that a sampled counter stream increments by one per valid sample.
// Locks after LOCK_N consecutive consistent samples, then flags mismatches.
// Optional feature: define COUNT_CHECKER_RESTART_DETECT_EN to treat a
// mismatching sample of 0 while locked as a counter restart (rst_seen)
// instead of an error. Without it rst_seen is held at 0.
// Input interface: a sample is consumed on every rising clk edge where
// valid is high; there is no backpressure.
module count_checker
    import count_checker_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LOCK_N = DEF_LOCK_N,
    parameter int ERR_W  = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             valid,
    input  logic [WIDTH-1:0] count,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic             wrap_pulse,
    output logic             rst_seen,
    output logic [WIDTH-1:0] expected
);

    localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_N);

    state_e           state_d, state_q;
    logic [RUN_W-1:0] run_d, run_q;
    logic [WIDTH-1:0] expected_d, expected_q;
    logic             err_pulse_d, err_pulse_q;
    logic             wrap_pulse_d, wrap_pulse_q;
    logic             rst_seen_d, rst_seen_q;
    logic             match;

    assign match = (count == expected_q);

    // Next-state, run tracking, expected value and pulse generation.
    always_comb begin
        state_d      = state_q;
        run_d        = run_q;
        expected_d   = expected_q;
        err_pulse_d  = 1'b0;
        wrap_pulse_d = 1'b0;
        rst_seen_d   = 1'b0;
        if (valid) begin
            expected_d = count + 1'b1;
            case (state_q)
                SEARCH: begin
                    // run == 0 only right after reset: first sample starts a run.
                    if (match && (run_q != '0)) run_d = run_q + 1'b1;
                    else                        run_d = RUN_W'(1);
                    if (run_d == LOCK_RUN) state_d = LOCKED;
                end
                LOCKED: begin
                    if (match) begin
                        wrap_pulse_d = (count == '0);
                    end else begin
                        state_d = SEARCH;
                        run_d   = RUN_W'(1);
`ifdef COUNT_CHECKER_RESTART_DETECT_EN
                        if (count == '0) rst_seen_d  = 1'b1;
                        else             err_pulse_d = 1'b1;
`else
                        err_pulse_d = 1'b1;
`endif
                    end
                end
                default: begin
                    state_d = SEARCH;
                    run_d   = '0;
                end
            endcase
        end
    end

    // State, run, expected and pulse registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= SEARCH;
            run_q        <= '0;
            expected_q   <= '0;
            err_pulse_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;
            rst_seen_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            expected_q   <= expected_d;
            err_pulse_q  <= err_pulse_d;
            wrap_pulse_q <= wrap_pulse_d;
            rst_seen_q   <= rst_seen_d;
        end
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clear (clear),
        .inc   (err_pulse_d),
        .cnt   (err_cnt)
    );

    assign locked     = (state_q == LOCKED);
    assign err_pulse  = err_pulse_q;
    assign wrap_pulse = wrap_pulse_q;
    assign rst_seen   = rst_seen_q;
    assign expected   = expected_q;

endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker: a vector table for the main sequence,
// plus hand-written sequences for saturation and asynchronous reset.
module tb_count_checker;

`ifdef COUNT_CHECKER_RESTART_DETECT_EN
    localparam int RD = 1;
`else
    localparam int RD = 0;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic       valid;
    logic [3:0] count;
    logic       clear;

    logic       locked, err_pulse, wrap_pulse, rst_seen;
    logic [7:0] err_cnt;
    logic [3:0] expected;

    logic       s_locked, s_err_pulse, s_wrap_pulse, s_rst_seen;
    logic [1:0] s_err_cnt;
    logic [3:0] s_expected;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int v, c, clr;
        int lk, ep, ec, wp, rs, ex;
    } vec_t;

    vec_t tbl[64];
    int   n_vec = 0;

    // Clock and DUT instances (default and 2-bit error counter).
    always #5 clk = ~clk;

    count_checker dut (
        .clk(clk), .rstn(rstn), .valid(valid), .count(count), .clear(clear),
        .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt),
        .wrap_pulse(wrap_pulse), .rst_seen(rst_seen), .expected(expected)
    );

    count_checker #(.ERR_W(2)) dut_s (
        .clk(clk), .rstn(rstn), .valid(valid), .count(count), .clear(clear),
        .locked(s_locked), .err_pulse(s_err_pulse), .err_cnt(s_err_cnt),
        .wrap_pulse(s_wrap_pulse), .rst_seen(s_rst_seen), .expected(s_expected)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one sample on the next falling edge; return 1ns after the rising edge.
    task automatic drive(input int v, input int c, input int clr);
        @(negedge clk);
        valid = v[0];
        count = c[3:0];
        clear = clr[0];
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int v, input int c, input int clr, input int lk,
                       input int ep, input int ec, input int wp, input int rs, input int ex);
        tbl[n_vec] = '{v, c, clr, lk, ep, ec, wp, rs, ex};
        n_vec++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " locked"},     locked,     0);
        chk({tag, " err_pulse"},  err_pulse,  0);
        chk({tag, " err_cnt"},    err_cnt,    0);
        chk({tag, " wrap_pulse"}, wrap_pulse, 0);
        chk({tag, " rst_seen"},   rst_seen,   0);
        chk({tag, " expected"},   expected,   0);
        chk({tag, " s_err_cnt"},  s_err_cnt,  0);
        chk({tag, " s_locked"},   s_locked,   0);
    endtask

    initial begin
        int e;
        int bad;

        rstn  = 1'b0;
        valid = 1'b0;
        count = '0;
        clear = 1'b0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;

        // valid c clr | locked ep err_cnt wrap rs expected
        add(1, 0, 0,  0, 0, 0, 0, 0, 1);
        add(1, 1, 0,  0, 0, 0, 0, 0, 2);
        add(1, 2, 0,  0, 0, 0, 0, 0, 3);
        add(1, 3, 0,  1, 0, 0, 0, 0, 4);   // lock on 4th sample
        add(1, 4, 0,  1, 0, 0, 0, 0, 5);
        add(1, 5, 0,  1, 0, 0, 0, 0, 6);
        add(1, 6, 0,  1, 0, 0, 0, 0, 7);
        add(1, 9, 0,  0, 1, 1, 0, 0, 10);  // error while locked
        add(1, 10, 0, 0, 0, 1, 0, 0, 11);
        add(1, 11, 0, 0, 0, 1, 0, 0, 12);
        add(1, 12, 0, 1, 0, 1, 0, 0, 13);  // relocked
        add(1, 13, 0, 1, 0, 1, 0, 0, 14);
        add(1, 14, 0, 1, 0, 1, 0, 0, 15);
        add(1, 15, 0, 1, 0, 1, 0, 0, 0);
        add(1, 0, 0,  1, 0, 1, 1, 0, 1);   // wrap 15 -> 0
        add(0, 7, 0,  1, 0, 1, 0, 0, 1);   // gap: everything holds
        add(0, 3, 0,  1, 0, 1, 0, 0, 1);
        add(0, 9, 0,  1, 0, 1, 0, 0, 1);
        for (int k = 1; k <= 8; k++) add(1, k, 0, 1, 0, 1, 0, 0, k + 1);
        add(1, 0, 0,  0, 1 - RD, 2 - RD, 0, RD, 1);  // restart / error on 0
        add(1, 1, 0,  0, 0, 2 - RD, 0, 0, 2);
        add(1, 2, 0,  0, 0, 2 - RD, 0, 0, 3);
        add(1, 3, 0,  1, 0, 2 - RD, 0, 0, 4);
        add(1, 9, 1,  0, 1, 0, 0, 0, 10);  // clear together with an error
        add(1, 10, 0, 0, 0, 0, 0, 0, 11);

        for (int i = 0; i < n_vec; i++) begin
            drive(tbl[i].v, tbl[i].c, tbl[i].clr);
            chk($sformatf("vec%0d locked", i),     locked,     tbl[i].lk);
            chk($sformatf("vec%0d err_pulse", i),  err_pulse,  tbl[i].ep);
            chk($sformatf("vec%0d err_cnt", i),    err_cnt,    tbl[i].ec);
            chk($sformatf("vec%0d wrap_pulse", i), wrap_pulse, tbl[i].wp);
            chk($sformatf("vec%0d rst_seen", i),   rst_seen,   tbl[i].rs);
            chk($sformatf("vec%0d expected", i),   expected,   tbl[i].ex);
        end

        // Saturation: five errors on the 2-bit counter instance.
        drive(0, 0, 0);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) drive(1, k, 0);
        chk("sat initial lock", s_locked, 1);
        e = 4;
        for (int k = 0; k < 5; k++) begin
            bad = (e + 5) % 16;
            if (bad == 0) bad = 1;
            drive(1, bad, 0);
            chk($sformatf("sat%0d err_pulse", k), s_err_pulse, 1);
            chk($sformatf("sat%0d s_err_cnt", k), s_err_cnt, (k + 1 > 3) ? 3 : k + 1);
            chk($sformatf("sat%0d err_cnt", k),   err_cnt,   k + 1);
            for (int j = 1; j <= 3; j++) drive(1, (bad + j) % 16, 0);
            chk($sformatf("sat%0d relock", k), s_locked, 1);
            e = (bad + 4) % 16;
        end
        bad = (e + 5) % 16;
        if (bad == 0) bad = 1;
        drive(1, bad, 1);
        chk("sat clear err_pulse", s_err_pulse, 1);
        chk("sat clear s_err_cnt", s_err_cnt, 0);
        chk("sat clear err_cnt",   err_cnt,   0);

        // Asynchronous reset mid-stream, then a full relock is required.
        for (int j = 1; j <= 4; j++) drive(1, (bad + j) % 16, 0);
        chk("pre-reset locked", locked, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk_all_zero("async reset");
        valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int j = 5; j <= 7; j++) begin
            drive(1, j, 0);
            chk($sformatf("relock wait %0d", j), locked, 0);
        end
        drive(1, 8, 0);
        chk("relock after reset", locked, 1);
        chk("relock expected", expected, 9);
        chk("relock err_cnt", err_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
